dsp_out_preg: RTL



---
 rtl/dsp_out_preg_if.sv | 28 ++
 rtl/dsp_out_preg.sv | 118 +++++++++++
 2 files changed

// File: rtl/dsp_out_preg_if.sv
// P-side bus of the DSP slice output stage: ALU result in, registered result,
// cascade copy, carry-outs and pattern-detector flags out.
interface dsp_out_preg_if;
  logic        CEP;
  logic [47:0] ALU_OUT;
  logic [3:0]  CARRY_IN;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic [3:0]  CARRYOUT;
  logic        PATTERNDETECT;
  logic        PATTERNBDETECT;
  logic        PATTERNDETECTPAST;
  logic        PATTERNBDETECTPAST;
  logic        OVERFLOW;
  logic        UNDERFLOW;

  modport master (
    output CEP, ALU_OUT, CARRY_IN,
    input  P, PCOUT, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
           PATTERNDETECTPAST, PATTERNBDETECTPAST, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  CEP, ALU_OUT, CARRY_IN,
    output P, PCOUT, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
           PATTERNDETECTPAST, PATTERNBDETECTPAST, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/dsp_out_preg.sv
// DSP slice output stage: P register, PCOUT cascade and pattern detector.
// Define DSP_PATDET_EN to build the detector, PAST history, OVERFLOW/UNDERFLOW and auto-reset.
module dsp_out_preg #(
  parameter int unsigned PREG             = 1,
  parameter logic [47:0] PATTERN          = 48'h0,
  parameter logic [47:0] MASK             = 48'h3FFF_FFFF_FFFF,
  parameter string       AUTORESET_PATDET = "NO_RESET"
) (
  input  logic          clk,
  input  logic          RSTP,
  dsp_out_preg_if.slave bus
);

`ifdef DSP_PATDET_EN
  localparam bit PATDET_EN = 1'b1;
`else
  localparam bit PATDET_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    AR_NONE      = 2'd0,
    AR_MATCH     = 2'd1,
    AR_NOT_MATCH = 2'd2
  } ar_mode_e;

  // Unknown auto-reset strings fall back to no auto-reset.
  localparam ar_mode_e AR_MODE =
    !PATDET_EN                              ? AR_NONE :
    (AUTORESET_PATDET == "RESET_MATCH")     ? AR_MATCH :
    (AUTORESET_PATDET == "RESET_NOT_MATCH") ? AR_NOT_MATCH : AR_NONE;

  function automatic logic pat_match(input logic [47:0] d, input logic [47:0] pat);
    return &(~(d ^ pat) | MASK);
  endfunction

  logic match_s;
  logic bmatch_s;
  logic zmatch_s;
  logic zbmatch_s;

  // Detector terms for the live ALU result and for the cleared (all-zero) value.
  always_comb begin
    match_s   = PATDET_EN & pat_match(bus.ALU_OUT, PATTERN);
    bmatch_s  = PATDET_EN & pat_match(bus.ALU_OUT, ~PATTERN);
    zmatch_s  = PATDET_EN & pat_match(48'h0, PATTERN);
    zbmatch_s = PATDET_EN & pat_match(48'h0, ~PATTERN);
  end

  generate
    if (PREG == 0) begin : g_comb
      assign bus.P                  = bus.ALU_OUT;
      assign bus.PCOUT              = bus.ALU_OUT;
      assign bus.CARRYOUT           = bus.CARRY_IN;
      assign bus.PATTERNDETECT      = match_s;
      assign bus.PATTERNBDETECT     = bmatch_s;
      assign bus.PATTERNDETECTPAST  = 1'b0;
      assign bus.PATTERNBDETECTPAST = 1'b0;
      assign bus.OVERFLOW           = 1'b0;
      assign bus.UNDERFLOW          = 1'b0;
    end else begin : g_reg
      logic [47:0] p_r;
      logic [3:0]  carry_r;
      logic        pd_r;
      logic        pbd_r;
      logic        pdp_r;
      logic        pbdp_r;
      logic        ar_s;

      // Auto-reset trigger decoded from the currently visible detect state.
      always_comb begin
        ar_s = 1'b0;
        case (AR_MODE)
          AR_MATCH:     ar_s = pd_r;
          AR_NOT_MATCH: ar_s = pdp_r & ~pd_r;
          default:      ar_s = 1'b0;
        endcase
      end

      // P / CARRYOUT / detector registers; RSTP dominates auto-reset, CEP=0 freezes all.
      always_ff @(posedge clk) begin
        if (RSTP) begin
          p_r     <= 48'h0;
          carry_r <= 4'h0;
          pd_r    <= 1'b0;
          pbd_r   <= 1'b0;
          pdp_r   <= 1'b0;
          pbdp_r  <= 1'b0;
        end else if (bus.CEP) begin
          pdp_r  <= pd_r;
          pbdp_r <= pbd_r;
          if (ar_s) begin
            p_r     <= 48'h0;
            carry_r <= 4'h0;
            pd_r    <= zmatch_s;
            pbd_r   <= zbmatch_s;
          end else begin
            p_r     <= bus.ALU_OUT;
            carry_r <= bus.CARRY_IN;
            pd_r    <= match_s;
            pbd_r   <= bmatch_s;
          end
        end
      end

      assign bus.P                  = p_r;
      assign bus.PCOUT              = p_r;
      assign bus.CARRYOUT           = carry_r;
      assign bus.PATTERNDETECT      = pd_r;
      assign bus.PATTERNBDETECT     = pbd_r;
      assign bus.PATTERNDETECTPAST  = pdp_r;
      assign bus.PATTERNBDETECTPAST = pbdp_r;
      // Flags leave the pattern window in one step: overflow from match, underflow from bmatch.
      assign bus.OVERFLOW           = pdp_r & ~pd_r & ~pbd_r;
      assign bus.UNDERFLOW          = pbdp_r & ~pd_r & ~pbd_r;
    end
  endgenerate

endmodule
